// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station.
// Holds dispatched ops until both operands are available. Operand wakeup
// comes from the common data bus (CDB), including a same-cycle bypass on
// allocation. The lowest-index ready entry is issued into a registered
// output stage that holds its value under exReady backpressure.
module alu_rs #(
    parameter int ENTRIES = 8,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6,
    parameter logic [TAG_W-1:0] TAG_FREE = {TAG_W{1'b1}}
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                aluEnable,
    input  logic [3*TAG_W+2*DATA_W+OP_W-1:0]    aluData,
    output logic                                rsFull,
    output logic [$clog2(ENTRIES+1)-1:0]        rsCount,
    input  logic                                cdbValid,
    input  logic [TAG_W-1:0]                    cdbTag,
    input  logic [DATA_W-1:0]                   cdbData,
    input  logic                                flush,
    output logic                                exValid,
    input  logic                                exReady,
    output logic [OP_W-1:0]                     exOp,
    output logic [DATA_W-1:0]                   exA,
    output logic [DATA_W-1:0]                   exB,
    output logic [TAG_W-1:0]                    exDest
);

    localparam int CNT_W   = $clog2(ENTRIES + 1);
    localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    // Field positions inside aluData = {dest, tag2, data2, tag1, data1, op}
    localparam int D1_LSB  = OP_W;
    localparam int T1_LSB  = D1_LSB + DATA_W;
    localparam int D2_LSB  = T1_LSB + TAG_W;
    localparam int T2_LSB  = D2_LSB + DATA_W;
    localparam int DST_LSB = T2_LSB + TAG_W;

    // A broadcast only satisfies an operand that is really waiting on it;
    // TAG_FREE is never treated as a producer tag.
    function automatic logic cdb_hit(input logic             v,
                                     input logic [TAG_W-1:0] ctag,
                                     input logic [TAG_W-1:0] t);
        return v && (t != TAG_FREE) && (t == ctag);
    endfunction

    // Entry state: control bits carry reset, payload does not (gated by valid)
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [OP_W-1:0]    op_q    [ENTRIES];
    logic [TAG_W-1:0]   dest_q  [ENTRIES];
    logic [TAG_W-1:0]   tag1_q  [ENTRIES];
    logic [TAG_W-1:0]   tag2_q  [ENTRIES];
    logic [DATA_W-1:0]  data1_q [ENTRIES];
    logic [DATA_W-1:0]  data2_q [ENTRIES];

    logic [CNT_W-1:0]   count_q, count_d;

    logic               exvalid_q;
    logic [OP_W-1:0]    exop_q;
    logic [DATA_W-1:0]  exa_q, exb_q;
    logic [TAG_W-1:0]   exdest_q;

    logic [OP_W-1:0]    in_op;
    logic [TAG_W-1:0]   in_dest, in_tag1, in_tag2;
    logic [DATA_W-1:0]  in_data1, in_data2;

    logic [ENTRIES-1:0] ready;
    logic               alloc_hit, iss_hit;
    logic [IDX_W-1:0]   alloc_idx, iss_idx;
    logic               do_alloc, do_issue, ex_load;

    assign in_op    = aluData[0 +: OP_W];
    assign in_data1 = aluData[D1_LSB +: DATA_W];
    assign in_tag1  = aluData[T1_LSB +: TAG_W];
    assign in_data2 = aluData[D2_LSB +: DATA_W];
    assign in_tag2  = aluData[T2_LSB +: TAG_W];
    assign in_dest  = aluData[DST_LSB +: TAG_W];

    // Full is taken from registered occupancy only; a same-cycle issue does not help
    assign rsFull   = (count_q == CNT_W'(ENTRIES));
    assign ex_load  = !exvalid_q || exReady;
    assign do_alloc = aluEnable && !rsFull && alloc_hit && !flush;
    assign do_issue = ex_load && iss_hit && !flush;

    // Readiness from registered tags, so a wakeup reaches issue one cycle later
    always_comb begin
        ready = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            ready[i] = valid_q[i] && (tag1_q[i] == TAG_FREE) && (tag2_q[i] == TAG_FREE);
        end
    end

    // Priority pick: lowest-index free slot for allocation, lowest-index ready slot for issue
    always_comb begin
        alloc_hit = 1'b0;
        alloc_idx = '0;
        iss_hit   = 1'b0;
        iss_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_hit = 1'b1;
                alloc_idx = IDX_W'(i);
            end
            if (ready[i]) begin
                iss_hit = 1'b1;
                iss_idx = IDX_W'(i);
            end
        end
    end

    // Next valid vector and occupancy; flush wins over alloc and issue
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < ENTRIES; i++) begin
            if (do_issue && (iss_idx == IDX_W'(i))) valid_d[i] = 1'b0;
            if (do_alloc && (alloc_idx == IDX_W'(i))) valid_d[i] = 1'b1;
        end
        if (flush) valid_d = '0;

        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (do_alloc && !do_issue) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_alloc && do_issue) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control state and issue output register, asynchronously reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            count_q   <= '0;
            exvalid_q <= 1'b0;
            exop_q    <= '0;
            exa_q     <= '0;
            exb_q     <= '0;
            exdest_q  <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            if (flush) begin
                exvalid_q <= 1'b0;
            end else if (ex_load) begin
                exvalid_q <= iss_hit;
                if (iss_hit) begin
                    exop_q   <= op_q[iss_idx];
                    exa_q    <= data1_q[iss_idx];
                    exb_q    <= data2_q[iss_idx];
                    exdest_q <= dest_q[iss_idx];
                end
            end
        end
    end

    // Entry payload: allocation with CDB bypass, otherwise per-operand wakeup
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (do_alloc && (alloc_idx == IDX_W'(i))) begin
                op_q[i]   <= in_op;
                dest_q[i] <= in_dest;
                if (cdb_hit(cdbValid, cdbTag, in_tag1)) begin
                    tag1_q[i]  <= TAG_FREE;
                    data1_q[i] <= cdbData;
                end else begin
                    tag1_q[i]  <= in_tag1;
                    data1_q[i] <= in_data1;
                end
                if (cdb_hit(cdbValid, cdbTag, in_tag2)) begin
                    tag2_q[i]  <= TAG_FREE;
                    data2_q[i] <= cdbData;
                end else begin
                    tag2_q[i]  <= in_tag2;
                    data2_q[i] <= in_data2;
                end
            end else if (valid_q[i] && !flush) begin
                if (cdb_hit(cdbValid, cdbTag, tag1_q[i])) begin
                    tag1_q[i]  <= TAG_FREE;
                    data1_q[i] <= cdbData;
                end
                if (cdb_hit(cdbValid, cdbTag, tag2_q[i])) begin
                    tag2_q[i]  <= TAG_FREE;
                    data2_q[i] <= cdbData;
                end
            end
        end
    end

    assign rsCount = count_q;
    assign exValid = exvalid_q;
    assign exOp    = exop_q;
    assign exA     = exa_q;
    assign exB     = exb_q;
    assign exDest  = exdest_q;

endmodule
